issue_instr_queue: RTL and testbench

//  Decoupling FIFO between the decode stage and the issue stage.

---
 rtl/issue_instr_queue_pkg.sv | 23 ++
 rtl/issue_instr_queue.sv | 114 +++++++++++
 tb/tb_issue_instr_queue.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_instr_queue_pkg.sv
// Shared types and instantiation defaults for the decode-to-issue queue.
package issue_instr_queue_pkg;

  localparam int unsigned ISSUE_QUEUE_DEPTH  = 4;
  localparam int unsigned ISSUE_QUEUE_MAX_CF = 2;

  // Decoded instruction as handed from decode to the issue-stage scoreboard.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [3:0]  fu;
  } scoreboard_entry_t;

  // One storage slot: the entry plus its control-flow tag.
  typedef struct packed {
    scoreboard_entry_t entry;
    logic              cf;
  } queue_slot_t;

endpackage

// File: rtl/issue_instr_queue.sv
// Decoupling FIFO between decode and issue. First-word-fall-through head,
// no empty or full bypass, and a running count of held control-flow entries
// so the frontend can throttle speculation.
module issue_instr_queue
  import issue_instr_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = ISSUE_QUEUE_DEPTH,
  parameter int unsigned MAX_CF = ISSUE_QUEUE_MAX_CF
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  scoreboard_entry_t        decoded_instr_i,
  input  logic                     decoded_instr_valid_i,
  input  logic                     is_ctrl_flow_i,
  output logic                     decoded_instr_ack_o,
  output scoreboard_entry_t        issue_instr_o,
  output logic                     issue_instr_valid_o,
  output logic                     issue_is_ctrl_flow_o,
  input  logic                     issue_instr_ack_i,
  output logic [$clog2(DEPTH):0]   usage_o,
  output logic                     full_o,
  output logic                     cf_limit_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAXCF = CNT_W'(MAX_CF);

  queue_slot_t      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] usage;
  logic [CNT_W-1:0] cf_cnt;
  logic             full;
  logic             cf_limit;
  logic             push;
  logic             pop;
  logic             cf_push;
  logic             cf_pop;
  logic             head_cf;

  assign full     = (usage == CNT_DEPTH);
  assign cf_limit = (cf_cnt == CNT_MAXCF);

  // Acceptance never looks at the issue-side ack, so a full queue refuses
  // a push even when the head leaves in the same cycle.
  assign decoded_instr_ack_o = decoded_instr_valid_i & ~full & ~flush_i
                             & ~(is_ctrl_flow_i & cf_limit);

  assign push    = decoded_instr_ack_o;
  assign issue_instr_valid_o = (usage != '0);
  assign pop     = issue_instr_valid_o & issue_instr_ack_i & ~flush_i;

  assign issue_instr_o        = mem[rd_ptr].entry;
  assign head_cf              = mem[rd_ptr].cf;
  assign issue_is_ctrl_flow_o = head_cf;

  assign cf_push = push & is_ctrl_flow_i;
  assign cf_pop  = pop & head_cf;

  assign usage_o    = usage;
  assign full_o     = full;
  assign cf_limit_o = cf_limit;

  // Storage write; contents are deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= '{entry: decoded_instr_i, cf: is_ctrl_flow_i};
    end
  end

  // Pointers and occupancy counters; flush wins over push and pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      usage  <= '0;
      cf_cnt <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      usage  <= '0;
      cf_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

      if (push && !pop)      usage <= usage + CNT_ONE;
      else if (pop && !push) usage <= usage - CNT_ONE;

      if (cf_push && !cf_pop)      cf_cnt <= cf_cnt + CNT_ONE;
      else if (cf_pop && !cf_push) cf_cnt <= cf_cnt - CNT_ONE;
    end
  end

  // Structural invariants of the queue.
  a_usage_max : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 usage <= CNT_DEPTH);
  a_cf_max    : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 cf_cnt <= CNT_MAXCF);
  a_cf_usage  : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 cf_cnt <= usage);
  a_no_empty_pop : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    !(pop && !issue_instr_valid_o));
  a_head_stable  : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    (issue_instr_valid_o && !issue_instr_ack_i && !flush_i)
                                    |=> $stable(issue_instr_o));

endmodule

// File: tb/tb_issue_instr_queue.sv
// Bench for issue_instr_queue: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_issue_instr_queue;
  import issue_instr_queue_pkg::*;

  localparam int DEPTH  = 4;
  localparam int MAX_CF = 2;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              flush_i = 1'b0;
  scoreboard_entry_t decoded_instr_i = '0;
  logic              decoded_instr_valid_i = 1'b0;
  logic              is_ctrl_flow_i = 1'b0;
  logic              decoded_instr_ack_o;
  scoreboard_entry_t issue_instr_o;
  logic              issue_instr_valid_o;
  logic              issue_is_ctrl_flow_o;
  logic              issue_instr_ack_i = 1'b0;
  logic [2:0]        usage_o;
  logic              full_o;
  logic              cf_limit_o;

  int tests = 0;
  int fails = 0;

  issue_instr_queue #(.DEPTH(DEPTH), .MAX_CF(MAX_CF)) dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .flush_i               (flush_i),
    .decoded_instr_i       (decoded_instr_i),
    .decoded_instr_valid_i (decoded_instr_valid_i),
    .is_ctrl_flow_i        (is_ctrl_flow_i),
    .decoded_instr_ack_o   (decoded_instr_ack_o),
    .issue_instr_o         (issue_instr_o),
    .issue_instr_valid_o   (issue_instr_valid_o),
    .issue_is_ctrl_flow_o  (issue_is_ctrl_flow_o),
    .issue_instr_ack_i     (issue_instr_ack_i),
    .usage_o               (usage_o),
    .full_o                (full_o),
    .cf_limit_o            (cf_limit_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: an ordered list of held entries.
  typedef struct {
    scoreboard_entry_t e;
    logic              cf;
  } mslot_t;

  mslot_t            mq[$];
  logic              m_push = 1'b0;
  logic              m_pop = 1'b0;
  logic              m_flush = 1'b0;
  scoreboard_entry_t m_in = '0;
  logic              m_in_cf = 1'b0;

  function automatic int m_cf_count();
    int n = 0;
    foreach (mq[i]) if (mq[i].cf) n++;
    return n;
  endfunction

  // Compare every cycle, mid-period, then remember what the edge will do.
  always @(negedge clk_i) begin
    int   n;
    int   ncf;
    logic e_ack;
    logic e_valid;
    if (rst_ni) begin
      n       = mq.size();
      ncf     = m_cf_count();
      e_valid = (n != 0);
      e_ack   = decoded_instr_valid_i && (n < DEPTH) && !flush_i
                && !(is_ctrl_flow_i && ncf == MAX_CF);
      check("cyc_ack",      decoded_instr_ack_o, e_ack);
      check("cyc_valid",    issue_instr_valid_o, e_valid);
      check("cyc_usage",    usage_o, n);
      check("cyc_full",     full_o, n == DEPTH);
      check("cyc_cf_limit", cf_limit_o, ncf == MAX_CF);
      if (e_valid) begin
        check("cyc_head",    issue_instr_o, mq[0].e);
        check("cyc_head_cf", issue_is_ctrl_flow_o, mq[0].cf);
      end
      m_push  = e_ack;
      m_pop   = e_valid && issue_instr_ack_i && !flush_i;
      m_flush = flush_i;
      m_in    = decoded_instr_i;
      m_in_cf = is_ctrl_flow_i;
    end else begin
      m_push  = 1'b0;
      m_pop   = 1'b0;
      m_flush = 1'b0;
    end
  end

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mq.delete();
    end else if (m_flush) begin
      mq.delete();
    end else begin
      if (m_pop) mq.delete(0);
      if (m_push) mq.push_back('{m_in, m_in_cf});
    end
  end

  function automatic scoreboard_entry_t mk(input logic [63:0] pc);
    scoreboard_entry_t e;
    e.pc    = pc;
    e.instr = pc[31:0] ^ 32'h0000_0013;
    e.rd    = pc[6:2];
    e.rs1   = pc[11:7];
    e.rs2   = pc[16:12];
    e.fu    = pc[3:0] ^ 4'h5;
    return e;
  endfunction

  task automatic offer(input logic v, input logic cf, input logic [63:0] pc,
                       input logic ack, input logic fl);
    decoded_instr_valid_i = v;
    is_ctrl_flow_i        = cf;
    decoded_instr_i       = mk(pc);
    issue_instr_ack_i     = ack;
    flush_i               = fl;
  endtask

  task automatic idle();
    offer(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] popped[$];
    int          sent;
    int          got;
    int          cyc;
    logic        do_pop;

    // Reset state
    idle();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid",    issue_instr_valid_o, 1'b0);
    check("rst_ack",      decoded_instr_ack_o, 1'b0);
    check("rst_usage",    usage_o, 3'd0);
    check("rst_full",     full_o, 1'b0);
    check("rst_cf_limit", cf_limit_o, 1'b0);
    #2 rst_ni = 1'b1;
    step();

    // 1: single push, one-cycle latency
    offer(1'b1, 1'b0, 64'h8000_0000, 1'b0, 1'b0);
    #1;
    check("t1_ack_t0",   decoded_instr_ack_o, 1'b1);
    check("t1_valid_t0", issue_instr_valid_o, 1'b0);
    step();
    idle();
    #1;
    check("t1_valid_t1", issue_instr_valid_o, 1'b1);
    check("t1_pc_t1",    issue_instr_o.pc, 64'h8000_0000);
    check("t1_usage_t1", usage_o, 3'd1);
    offer(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    step();
    idle();
    #1;
    check("t1_usage_drained", usage_o, 3'd0);

    // 2: fill, refuse when full, refuse push alongside a pop while full
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 1'b0, 64'h100 + 64'(4 * i), 1'b0, 1'b0);
      step();
    end
    idle();
    #1;
    check("t2_full",  full_o, 1'b1);
    check("t2_usage", usage_o, 3'd4);
    offer(1'b1, 1'b0, 64'h200, 1'b0, 1'b0);
    #1;
    check("t2_ack_full", decoded_instr_ack_o, 1'b0);
    offer(1'b1, 1'b0, 64'h200, 1'b1, 1'b0);
    #1;
    check("t2_ack_full_pop",   decoded_instr_ack_o, 1'b0);
    check("t2_usage_full_pop", usage_o, 3'd4);
    step();
    idle();
    #1;
    check("t2_usage_after_pop", usage_o, 3'd3);
    check("t2_full_after_pop",  full_o, 1'b0);
    check("t2_head_after_pop",  issue_instr_o.pc, 64'h104);
    offer(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    repeat (3) step();
    idle();
    #1;
    check("t2_drained", usage_o, 3'd0);

    // 3: streaming with pops every other cycle over three wraps
    sent = 0;
    got  = 0;
    cyc  = 0;
    while ((sent < 12 || got < 12) && cyc < 200) begin
      do_pop = cyc[0];
      offer(sent < 12, 1'b0, 64'h1000 + 64'(4 * sent), do_pop, 1'b0);
      #1;
      if (do_pop && issue_instr_valid_o) begin
        popped.push_back(issue_instr_o.pc);
        got++;
      end
      if (decoded_instr_ack_o) sent++;
      step();
      cyc++;
    end
    idle();
    if (cyc >= 200) check("t3_timeout", 1'b1, 1'b0);
    check("t3_count", popped.size(), 12);
    foreach (popped[i]) check($sformatf("t3_order_%0d", i), popped[i], 64'h1000 + 64'(4 * i));
    #1;
    check("t3_empty", usage_o, 3'd0);

    // 4: control-flow limit
    offer(1'b1, 1'b1, 64'h2000, 1'b0, 1'b0);
    step();
    offer(1'b1, 1'b1, 64'h2004, 1'b0, 1'b0);
    step();
    idle();
    #1;
    check("t4_cf_limit", cf_limit_o, 1'b1);
    check("t4_usage2",   usage_o, 3'd2);
    offer(1'b1, 1'b1, 64'h2008, 1'b0, 1'b0);
    #1;
    check("t4_cf_refused", decoded_instr_ack_o, 1'b0);
    offer(1'b1, 1'b0, 64'h200C, 1'b0, 1'b0);
    #1;
    check("t4_noncf_accepted", decoded_instr_ack_o, 1'b1);
    step();
    offer(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    #1;
    check("t4_head_is_cf", issue_is_ctrl_flow_o, 1'b1);
    step();
    idle();
    #1;
    check("t4_cf_limit_clear", cf_limit_o, 1'b0);
    check("t4_usage_after",    usage_o, 3'd2);
    check("t4_head_after",     issue_instr_o.pc, 64'h2004);
    offer(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    repeat (2) step();
    idle();

    // 5: flush with valid and ack both high
    offer(1'b1, 1'b1, 64'h3000, 1'b0, 1'b0);
    step();
    offer(1'b1, 1'b0, 64'h3004, 1'b0, 1'b0);
    step();
    offer(1'b1, 1'b1, 64'h3008, 1'b0, 1'b0);
    step();
    idle();
    #1;
    check("t5_usage3", usage_o, 3'd3);
    offer(1'b1, 1'b0, 64'h300C, 1'b1, 1'b1);
    #1;
    check("t5_ack_flush", decoded_instr_ack_o, 1'b0);
    step();
    idle();
    #1;
    check("t5_usage0",    usage_o, 3'd0);
    check("t5_valid0",    issue_instr_valid_o, 1'b0);
    check("t5_cf_limit0", cf_limit_o, 1'b0);
    step();
    check("t5_still_empty", usage_o, 3'd0);

    // 6: asynchronous reset mid-burst
    offer(1'b1, 1'b0, 64'h4000, 1'b0, 1'b0);
    step();
    offer(1'b1, 1'b0, 64'h4004, 1'b0, 1'b0);
    step();
    idle();
    #1;
    check("t6_usage2", usage_o, 3'd2);
    offer(1'b1, 1'b0, 64'h4008, 1'b0, 1'b0);
    #1;
    rst_ni = 1'b0;
    #1;
    check("t6_rst_valid", issue_instr_valid_o, 1'b0);
    check("t6_rst_usage", usage_o, 3'd0);
    idle();
    step();
    #1 rst_ni = 1'b1;
    offer(1'b1, 1'b0, 64'h5000, 1'b0, 1'b0);
    #1;
    check("t6_post_valid_t0", issue_instr_valid_o, 1'b0);
    step();
    idle();
    #1;
    check("t6_post_valid_t1", issue_instr_valid_o, 1'b1);
    check("t6_post_pc",       issue_instr_o.pc, 64'h5000);
    check("t6_post_usage",    usage_o, 3'd1);
    offer(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    step();
    idle();
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
